// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and width defaults for the register-file dump reader.
// Widths track the core register file so both sides agree.
package regfile_dump_reader_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register index range through a spare read port and streams
// each captured word with its index over a valid/ready interface.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int ZERO_X0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_idx,
    input  logic [ADDR_W-1:0] last_idx,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    state_e            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_q;
    logic              is_x0;

    // Address comes straight from a flop so the read port sees a stable index.
    assign rf_addr = idx;
    assign busy    = (state == ST_READ) || (state == ST_SEND);
    assign done    = (state == ST_DONE);
    assign is_x0   = (ZERO_X0 != 0) && (idx == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            last_q     <= '0;
            dump_idx   <= '0;
            dump_data  <= '0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (first_idx <= last_idx) begin
                            idx    <= first_idx;
                            last_q <= last_idx;
                            state  <= ST_READ;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (abort) begin
                        dump_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        dump_data  <= is_x0 ? '0 : rf_rdata;
                        dump_idx   <= idx;
                        dump_last  <= (idx == last_q);
                        dump_valid <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Abort wins over a same-cycle handshake.
                    if (abort) begin
                        dump_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (dump_ready) begin
                        dump_valid <= 1'b0;
                        if (idx == last_q) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for the register-file dump reader.
// A behavioural register file feeds the read port.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  first_idx;
    logic [4:0]  last_idx;
    logic [4:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        dump_last;
    logic        busy;
    logic        done;
    logic        cfg_err;

    logic [31:0] rf [32];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_hs   = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf[rf_addr];

    regfile_dump_reader #(
        .DATA_W (32),
        .ADDR_W (5),
        .ZERO_X0(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .first_idx (first_idx),
        .last_idx  (last_idx),
        .rf_addr   (rf_addr),
        .rf_rdata  (rf_rdata),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_idx  (dump_idx),
        .dump_data (dump_data),
        .dump_last (dump_last),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always @(posedge clk)
        if (!rst && dump_valid && dump_ready && !abort)
            n_hs <= n_hs + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expd(input int i);
        return (i == 0) ? 32'h0 : 32'h100 + i;
    endfunction

    task automatic wait_valid();
        int n = 0;
        while (!dump_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", {31'b0, dump_valid}, 32'd1);
    endtask

    task automatic get_beat(input int ei, input int li, input int stalls);
        logic [31:0] hd;
        wait_valid();
        hd = dump_data;
        for (int s = 0; s < stalls; s++) begin
            dump_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", {31'b0, dump_valid}, 32'd1);
            chk("hold_idx", {27'b0, dump_idx}, ei);
            chk("hold_data", dump_data, hd);
            chk("hold_last", {31'b0, dump_last}, {31'b0, ei == li});
        end
        dump_ready = 1'b1;
        chk("beat_idx", {27'b0, dump_idx}, ei);
        chk("beat_data", dump_data, expd(ei));
        chk("beat_last", {31'b0, dump_last}, {31'b0, ei == li});
        @(posedge clk);
        #1;
        chk("valid_drop", {31'b0, dump_valid}, 32'd0);
    endtask

    task automatic do_start(input int f, input int l);
        @(negedge clk);
        first_idx = f[4:0];
        last_idx  = l[4:0];
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int h0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[0] = 32'hDEADBEEF;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        first_idx = '0; last_idx = '0; dump_ready = 1'b1;
        #12;
        chk("rst_valid", {31'b0, dump_valid}, 32'd0);
        chk("rst_addr", {27'b0, rf_addr}, 32'd0);
        chk("rst_data", dump_data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // full dump, ready high
        do_start(0, 31);
        chk("lat1_valid", {31'b0, dump_valid}, 32'd0);
        chk("lat1_busy", {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("lat2_valid", {31'b0, dump_valid}, 32'd1);
        for (int i = 0; i < 32; i++) get_beat(i, 31, 0);
        chk("full_done", {31'b0, done}, 32'd1);
        chk("full_busy", {31'b0, busy}, 32'd0);
        chk("full_hs", n_hs, 32);
        @(posedge clk);
        #1;
        chk("done_pulse", {31'b0, done}, 32'd0);

        // back-pressure
        h0 = n_hs;
        do_start(5, 7);
        for (int i = 5; i <= 7; i++) get_beat(i, 7, 2);
        chk("bp_done", {31'b0, done}, 32'd1);
        chk("bp_hs", n_hs - h0, 3);
        @(posedge clk);
        #1;

        // bad range
        h0 = n_hs;
        do_start(9, 4);
        chk("err_pulse", {31'b0, cfg_err}, 32'd1);
        chk("err_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("err_clear", {31'b0, cfg_err}, 32'd0);
        chk("err_valid", {31'b0, dump_valid}, 32'd0);
        chk("err_hs", n_hs - h0, 0);

        // abort during third beat
        h0 = n_hs;
        do_start(0, 31);
        get_beat(0, 31, 0);
        get_beat(1, 31, 0);
        wait_valid();
        chk("ab_idx", {27'b0, dump_idx}, 32'd2);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("ab_valid", {31'b0, dump_valid}, 32'd0);
        chk("ab_busy", {31'b0, busy}, 32'd0);
        chk("ab_done", {31'b0, done}, 32'd0);
        chk("ab_hs", n_hs - h0, 2);
        do_start(3, 3);
        get_beat(3, 3, 0);
        chk("single_done", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;

        // async reset mid-send
        do_start(0, 31);
        dump_ready = 1'b0;
        wait_valid();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, dump_valid}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_data", dump_data, 32'd0);
        chk("arst_addr", {27'b0, rf_addr}, 32'd0);
        chk("arst_last", {31'b0, dump_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dump_ready = 1'b1;
        do_start(31, 31);
        get_beat(31, 31, 0);
        chk("r31_done", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;

        // start while busy is ignored
        h0 = n_hs;
        do_start(10, 12);
        get_beat(10, 12, 0);
        @(negedge clk);
        first_idx = 5'd0;
        last_idx  = 5'd31;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        get_beat(11, 12, 0);
        get_beat(12, 12, 0);
        chk("busy_done", {31'b0, done}, 32'd1);
        chk("busy_hs", n_hs - h0, 3);
        @(posedge clk);
        #1;
        chk("busy_idle", {31'b0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
